// File: rtl/matrix_mul_seq_if.sv
// Job/result handshake bundle for matrix_mul_seq.
// master drives jobs and consumes results; slave is the multiplier.
interface matrix_mul_seq_if #(
    parameter int bitlength = 8,
    parameter int M1_D1     = 3,
    parameter int M1_D2     = 4,
    parameter int M2_D2     = 2,
    parameter int ACC_W     = 20
);
    logic [M1_D1*M1_D2*bitlength-1:0] AI;
    logic [M1_D2*M2_D2*bitlength-1:0] BI;
    logic                             acc_mode;
    logic                             in_valid;
    logic                             in_ready;
    logic [M1_D1*M2_D2*ACC_W-1:0]     CO;
    logic                             out_valid;
    logic                             out_ready;
    logic                             ovf;

    modport master (
        output AI,
        output BI,
        output acc_mode,
        output in_valid,
        output out_ready,
        input  in_ready,
        input  CO,
        input  out_valid,
        input  ovf
    );

    modport slave (
        input  AI,
        input  BI,
        input  acc_mode,
        input  in_valid,
        input  out_ready,
        output in_ready,
        output CO,
        output out_valid,
        output ovf
    );
endinterface

// File: rtl/matrix_mul_seq.sv
// Sequential C = A*B (or C += A*B) with one MAC per C element,
// one k-step per clock, valid/ready job and result handshakes.
module matrix_mul_seq #(
    parameter int bitlength = 8,
    parameter int M1_D1     = 3,
    parameter int M1_D2     = 4,
    parameter int M2_D2     = 2,
    parameter int ACC_W     = 20,
    parameter int SIGNED    = 0
) (
    input  logic            clk,
    input  logic            rst_n,
    matrix_mul_seq_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        COMPUTE,
        DONE
    } state_t;

    localparam int KW     = (M1_D2 > 1) ? $clog2(M1_D2) : 1;
    localparam int PROD_W = 2 * bitlength + 2;
    localparam int NEL    = M1_D1 * M2_D2;
    localparam logic [KW-1:0] K_LAST = KW'(M1_D2 - 1);

    state_t               state;
    logic [KW-1:0]        k;
    logic                 ovf_q;
    logic                 accept;
    logic [NEL-1:0]       ovf_vec;
    logic [NEL*ACC_W-1:0] co;

    logic [bitlength-1:0] a_q     [M1_D1][M1_D2];
    logic [bitlength-1:0] b_q     [M1_D2][M2_D2];
    logic [ACC_W-1:0]     acc     [M1_D1][M2_D2];
    logic [ACC_W-1:0]     acc_nxt [M1_D1][M2_D2];

    assign bus.in_ready  = (state == IDLE) ||
                           ((state == DONE) && bus.out_ready);
    assign bus.out_valid = (state == DONE);
    assign bus.ovf       = ovf_q;
    assign bus.CO        = co;
    assign accept        = bus.in_valid && bus.in_ready;

    // Operands get a sign bit (zero when unsigned) so one signed
    // multiplier serves both modes; sign-extending then covers both.
    for (genvar i = 0; i < M1_D1; i++) begin : g_row
        for (genvar j = 0; j < M2_D2; j++) begin : g_col
            logic [bitlength-1:0]      a_el;
            logic [bitlength-1:0]      b_el;
            logic signed [bitlength:0] a_x;
            logic signed [bitlength:0] b_x;
            logic signed [PROD_W-1:0]  prod;
            logic [ACC_W-1:0]          ext;
            logic [ACC_W:0]            sum;
            logic                      sgn_ov;

            assign a_el = a_q[i][k];
            assign b_el = b_q[k][j];
            assign a_x  = {(SIGNED != 0) && a_el[bitlength-1], a_el};
            assign b_x  = {(SIGNED != 0) && b_el[bitlength-1], b_el};
            assign prod = PROD_W'(a_x) * PROD_W'(b_x);
            assign ext  = ACC_W'(prod);
            assign sum  = {1'b0, acc[i][j]} + {1'b0, ext};

            assign sgn_ov =
                (acc[i][j][ACC_W-1] == ext[ACC_W-1]) &&
                (sum[ACC_W-1] != acc[i][j][ACC_W-1]);

            assign acc_nxt[i][j] = sum[ACC_W-1:0];
            assign ovf_vec[i*M2_D2+j] =
                (SIGNED != 0) ? sgn_ov : sum[ACC_W];
        end
    end

    always_comb begin
        co = '0;
        for (int i = 0; i < M1_D1; i++) begin
            for (int j = 0; j < M2_D2; j++) begin
                co[(i*M2_D2+j)*ACC_W +: ACC_W] = acc[i][j];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            k     <= '0;
            ovf_q <= 1'b0;
            for (int i = 0; i < M1_D1; i++) begin
                for (int j = 0; j < M2_D2; j++) begin
                    acc[i][j] <= '0;
                end
                for (int kk = 0; kk < M1_D2; kk++) begin
                    a_q[i][kk] <= '0;
                end
            end
            for (int kk = 0; kk < M1_D2; kk++) begin
                for (int j = 0; j < M2_D2; j++) begin
                    b_q[kk][j] <= '0;
                end
            end
        end else begin
            unique case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        for (int i = 0; i < M1_D1; i++) begin
                            for (int kk = 0; kk < M1_D2; kk++) begin
                                a_q[i][kk] <= bus.AI[(i*M1_D2+kk)*bitlength +: bitlength];
                            end
                        end
                        for (int kk = 0; kk < M1_D2; kk++) begin
                            for (int j = 0; j < M2_D2; j++) begin
                                b_q[kk][j] <= bus.BI[(kk*M2_D2+j)*bitlength +: bitlength];
                            end
                        end
                        if (!bus.acc_mode) begin
                            for (int i = 0; i < M1_D1; i++) begin
                                for (int j = 0; j < M2_D2; j++) begin
                                    acc[i][j] <= '0;
                                end
                            end
                        end
                        k     <= '0;
                        ovf_q <= 1'b0;
                        state <= COMPUTE;
                    end else if ((state == DONE) && bus.out_ready) begin
                        state <= IDLE;
                    end
                end
                COMPUTE: begin
                    acc <= acc_nxt;
                    if (|ovf_vec) begin
                        ovf_q <= 1'b1;
                    end
                    if (k == K_LAST) begin
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
